// File: rtl/instr_issue_encoder.sv
// -----------------------------------------------------------------------------
// instr_issue_encoder
//
// Producer side of the processor instruction interface. Decoded operation
// fields are accepted on a valid/ready handshake, and valid opcodes are
// buffered in a small FIFO. Each cycle one 32-bit word goes to the processor
// top. The word is either the packed FIFO head or a NOP bubble. A bubble is
// sent when the FIFO is empty, or when the head reads a register that one of
// the last HAZARD_WIN issued instructions writes.
//
// Handshake: a transfer happens on a rising edge where in_valid && in_ready
// && !flush. in_ready depends only on the registered occupancy, so a pop in
// the same cycle never frees room for that cycle's push. A transfer that
// carries an invalid opcode is consumed but not stored. bad_opcode pulses
// on the following cycle.
//
// Ports
//   clk          in   1    clock, rising edge
//   rst_n        in   1    asynchronous active-low reset
//   flush        in   1    synchronous: drop FIFO contents and hazard history
//   in_valid     in   1    field set presented
//   in_ready     out  1    FIFO can accept (= !full)
//   in_opcode    in   6    operation code          (word bits [5:0])
//   in_src1      in   5    first source register   (word bits [10:6])
//   in_src2      in   5    second source register  (word bits [15:11])
//   in_dst       in   5    destination register    (word bits [20:16])
//   instruction  out  32   registered instruction word
//   issue_valid  out  1    1 = instruction is a real op, 0 = NOP
//   bad_opcode   out  1    1-cycle pulse: an accepted opcode was dropped
//   stall        out  1    1 = current NOP is due to a head hazard
//   fifo_count   out  CW   current FIFO occupancy
//   state_o      out  2    FSM state (0 IDLE, 1 RUN, 2 STALL), for debug
// -----------------------------------------------------------------------------
module instr_issue_encoder #(
    parameter int          FIFO_DEPTH = 4,
    parameter int          HAZARD_WIN = 2,
    parameter logic [5:0]  NOP_OPCODE = 6'd0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [5:0]                    in_opcode,
    input  logic [4:0]                    in_src1,
    input  logic [4:0]                    in_src2,
    input  logic [4:0]                    in_dst,
    output logic [31:0]                   instruction,
    output logic                          issue_valid,
    output logic                          bad_opcode,
    output logic                          stall,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [1:0]                    state_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_t;

    // Opcode map of the processor. NOP_OPCODE must be outside this set.
    function automatic logic op_is_valid(input logic [5:0] op);
        case (op)
            6'd1, 6'd3, 6'd5, 6'd7, 6'd9, 6'd10, 6'd11,
            6'd12, 6'd13, 6'd14, 6'd15: op_is_valid = 1'b1;
            default:                    op_is_valid = 1'b0;
        endcase
    endfunction

    // FIFO entry layout is the low 21 bits of the word: {dst, src2, src1, opcode}
    logic [20:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;

    // Hazard history; index 0 is the most recently issued word
    logic [HAZARD_WIN-1:0] hist_v_q;
    logic [4:0]            hist_dst_q [HAZARD_WIN];

    state_t      state_q, state_d;
    logic [31:0] instr_q;
    logic        issue_valid_q, stall_q, bad_q;

    logic        full, fire, push, bad_d, have_head, hazard, pop;
    logic [20:0] head;

    always_comb begin
        full      = (count_q == CW'(FIFO_DEPTH));
        fire      = in_valid && !full && !flush;
        push      = fire && op_is_valid(in_opcode);
        bad_d     = fire && !op_is_valid(in_opcode);
        have_head = (count_q != '0);
        head      = mem_q[rd_ptr_q];

        // Register 0 is checked like any other register.
        hazard = 1'b0;
        for (int i = 0; i < HAZARD_WIN; i++) begin
            if (hist_v_q[i] && ((hist_dst_q[i] == head[10:6]) ||
                                (hist_dst_q[i] == head[15:11]))) begin
                hazard = 1'b1;
            end
        end

        pop = have_head && !hazard && !flush;

        if (flush || !have_head) state_d = IDLE;
        else if (hazard)         state_d = STALL;
        else                     state_d = RUN;

        count_d = count_q + CW'(push) - CW'(pop);
    end

    // Storage array is not reset; entries are only read once count covers them.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {in_dst, in_src2, in_src1, in_opcode};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            instr_q       <= 32'h0;
            issue_valid_q <= 1'b0;
            stall_q       <= 1'b0;
            bad_q         <= 1'b0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            hist_v_q      <= '0;
            for (int i = 0; i < HAZARD_WIN; i++) hist_dst_q[i] <= '0;
        end else if (flush) begin
            state_q       <= IDLE;
            instr_q       <= {26'b0, NOP_OPCODE};
            issue_valid_q <= 1'b0;
            stall_q       <= 1'b0;
            bad_q         <= 1'b0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            hist_v_q      <= '0;
        end else begin
            state_q  <= state_d;
            bad_q    <= bad_d;
            count_q  <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);

            case (state_d)
                RUN: begin
                    instr_q       <= {11'b0, head};
                    issue_valid_q <= 1'b1;
                    stall_q       <= 1'b0;
                end
                STALL: begin
                    instr_q       <= {26'b0, NOP_OPCODE};
                    issue_valid_q <= 1'b0;
                    stall_q       <= 1'b1;
                end
                default: begin
                    instr_q       <= {26'b0, NOP_OPCODE};
                    issue_valid_q <= 1'b0;
                    stall_q       <= 1'b0;
                end
            endcase

            // A bubble enters the history as invalid; its dst field is don't-care.
            for (int i = HAZARD_WIN - 1; i > 0; i--) begin
                hist_v_q[i]   <= hist_v_q[i-1];
                hist_dst_q[i] <= hist_dst_q[i-1];
            end
            hist_v_q[0]   <= pop;
            hist_dst_q[0] <= head[20:16];
        end
    end

    assign in_ready    = !full;
    assign instruction = instr_q;
    assign issue_valid = issue_valid_q;
    assign bad_opcode  = bad_q;
    assign stall       = stall_q;
    assign fifo_count  = count_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_instr_issue_encoder.sv
module tb_instr_issue_encoder;

  localparam int         FIFO_DEPTH = 4;
  localparam int         HAZARD_WIN = 2;
  localparam logic [5:0] NOP_OPCODE = 6'd0;
  localparam logic [31:0] NOP_WORD  = {26'b0, NOP_OPCODE};

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [5:0]  in_opcode = '0;
  logic [4:0]  in_src1 = '0, in_src2 = '0, in_dst = '0;
  logic        in_ready, issue_valid, bad_opcode, stall;
  logic [31:0] instruction;
  logic [2:0]  fifo_count;
  logic [1:0]  state_o;

  always #5 clk = ~clk;

  instr_issue_encoder #(
    .FIFO_DEPTH(FIFO_DEPTH), .HAZARD_WIN(HAZARD_WIN), .NOP_OPCODE(NOP_OPCODE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_src1(in_src1), .in_src2(in_src2), .in_dst(in_dst),
    .instruction(instruction), .issue_valid(issue_valid), .bad_opcode(bad_opcode),
    .stall(stall), .fifo_count(fifo_count), .state_o(state_o)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_vec = 0;
  int n_err = 0;

  logic [20:0] exp_q[$];   // queued field sets, head at index 0
  int          hist[$];    // dst of the last HAZARD_WIN issued words, -1 = bubble
  logic [31:0] exp_instr;
  logic        exp_iv, exp_stall, exp_bad;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit op_ok(input logic [5:0] op);
    return op inside {6'd1, 6'd3, 6'd5, 6'd7, [6'd9:6'd15]};
  endfunction

  function automatic bit model_hazard();
    logic [20:0] h;
    if (exp_q.size() == 0) return 1'b0;
    h = exp_q[0];
    foreach (hist[i])
      if (hist[i] >= 0 && (hist[i] == int'(h[10:6]) || hist[i] == int'(h[15:11]))) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    hist.delete();
    repeat (HAZARD_WIN) hist.push_back(-1);
    exp_instr = 32'h0;
    exp_iv = 1'b0;
    exp_stall = 1'b0;
    exp_bad = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    bit          have, hz, fire;
    logic [20:0] w;
    have = exp_q.size() > 0;
    hz   = model_hazard();
    if (flush) begin
      model_reset();
      exp_instr = NOP_WORD;
    end else begin
      fire = in_valid && (exp_q.size() < FIFO_DEPTH);
      if (have && !hz) begin
        w = exp_q.pop_front();
        exp_instr = {11'b0, w};
        exp_iv = 1'b1;
        exp_stall = 1'b0;
        hist.push_front(int'(w[20:16]));
      end else begin
        exp_instr = NOP_WORD;
        exp_iv = 1'b0;
        exp_stall = have;
        hist.push_front(-1);
      end
      void'(hist.pop_back());
      exp_bad = fire && !op_ok(in_opcode);
      if (fire && op_ok(in_opcode)) exp_q.push_back({in_dst, in_src2, in_src1, in_opcode});
    end
  endtask

  task automatic compare_outputs();
    check("instruction", instruction, exp_instr);
    check("issue_valid", 32'(issue_valid), 32'(exp_iv));
    check("stall", 32'(stall), 32'(exp_stall));
    check("bad_opcode", 32'(bad_opcode), 32'(exp_bad));
    check("fifo_count", 32'(fifo_count), 32'(exp_q.size()));
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic v, input logic [5:0] op, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [4:0] d, input logic fl);
    @(negedge clk);
    in_valid = v; in_opcode = op; in_src1 = s1; in_src2 = s2; in_dst = d; flush = fl;
    #1;
    check("in_ready", 32'(in_ready), 32'(exp_q.size() < FIFO_DEPTH));
    model_step();
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  // Push one field set, retrying while the FIFO is full.
  task automatic push_wait(input logic [5:0] op, input logic [4:0] s1,
                           input logic [4:0] s2, input logic [4:0] d);
    bit acc;
    int tries;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 40) begin
      acc = exp_q.size() < FIFO_DEPTH;
      cycle(1'b1, op, s1, s2, d, 1'b0);
      tries++;
    end
    if (!acc) check("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic async_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    #1;
    model_reset();
    check("rst_instruction", instruction, 32'h0);
    check("rst_issue_valid", 32'(issue_valid), 32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_bad_opcode", 32'(bad_opcode), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int stalls;
    int max_cnt;
    bit seen;
    logic [5:0] op;

    model_reset();
    #1;
    check("rst_instruction", instruction, 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Encode: one push into an empty FIFO, issued on the next edge
    cycle(1'b1, 6'd3, 5'd1, 5'd2, 5'd4, 1'b0);
    idle(1);
    check("encode_word", instruction, 32'h0004_1043);
    check("encode_valid", 32'(issue_valid), 32'd1);
    idle(3);

    // Hazard: dependent pair back-to-back, two bubbles expected
    cycle(1'b1, 6'd3, 5'd1, 5'd2, 5'd4, 1'b0);
    cycle(1'b1, 6'd15, 5'd4, 5'd5, 5'd6, 1'b0);
    check("haz_first", instruction, 32'h0004_1043);
    stalls = 0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      idle(1);
      if (stall) stalls++;
      if (instruction == 32'h0006_290F && issue_valid) seen = 1'b1;
    end
    check("haz_stall_cycles", 32'(stalls), 32'd2);
    check("haz_second_issued", 32'(seen), 32'd1);

    // Invalid opcode: consumed, not stored
    cycle(1'b1, 6'd2, 5'd1, 5'd1, 5'd1, 1'b0);
    check("bad_pulse", 32'(bad_opcode), 32'd1);
    idle(1);
    check("bad_once", 32'(bad_opcode), 32'd0);
    idle(2);

    // Full: dependent chain fills the FIFO while bubbles are issued
    max_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      push_wait(6'd1, 5'(k + 8), 5'(k + 8), 5'(k + 9));
      if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
    end
    check("full_reached", 32'(max_cnt), 32'(FIFO_DEPTH));
    idle(30);

    // Flush with queued entries, concurrent handshake ignored
    for (int k = 0; k < 4; k++) push_wait(6'd5, 5'(k + 20), 5'(k + 20), 5'(k + 21));
    check("flush_precount", 32'(fifo_count >= 3), 32'd1);
    cycle(1'b1, 6'd7, 5'd9, 5'd9, 5'd9, 1'b1);
    check("flush_count", 32'(fifo_count), 32'd0);
    check("flush_nop", instruction, NOP_WORD);
    check("flush_stall", 32'(stall), 32'd0);
    cycle(1'b1, 6'd9, 5'd21, 5'd22, 5'd23, 1'b0);
    idle(1);
    check("flush_after_issue", 32'(issue_valid), 32'd1);
    idle(2);

    // Reset mid-stream
    for (int k = 0; k < 3; k++) push_wait(6'd11, 5'(k + 1), 5'(k + 1), 5'(k + 2));
    async_reset();
    idle(2);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(16, 63)) : 6'($urandom_range(0, 15));
      cycle(1'($urandom_range(0, 1)), op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 1'($urandom_range(0, 39) == 0));
      if ($urandom_range(0, 299) == 0) async_reset();
    end
    idle(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
